// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // Expected parity bit for a word; narrower words are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_calc(input logic [8:0] data, input parity_e mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: os_tick pulses one clk every CLK_DIV clks; clr realigns the phase.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic os_tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign os_tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with parity/stop options, error flags and ready/valid output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on each bit decision.
module uart_rx_os #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16,
  parameter int CLK_DIV   = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  import uart_pkg::*;

  localparam int OW = $clog2(OVS);
  localparam int BW = 4;
  localparam logic [OW-1:0] MID  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] LAST = OW'(OVS - 1);
  localparam parity_e PMODE = parity_e'(PARITY);

  logic [1:0]           sync;
  logic                 rxd_s, os_tick, start_det, bit_s;
  rx_state_e            state;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, ferr_acc, ferr_new, perr_new, last_stop, hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rxd};
  end
  assign rxd_s = sync[1];

  assign start_det = (state == ST_IDLE) && !rxd_s;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_det),
    .os_tick (os_tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous tick samples; the current tick's sample is rxd_s itself, so timing is unchanged.
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hist <= 2'b11;
    else if (os_tick) hist <= {hist[0], rxd_s};
  end
  assign bit_s = (rxd_s & hist[0]) | (rxd_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign bit_s = rxd_s;
`endif

  assign ferr_new  = ferr_acc | ~bit_s;
  assign perr_new  = (PARITY != 0) && (parity_calc(9'(shreg), PMODE) != par_bit);
  assign last_stop = (state == ST_STOP) && os_tick && (os_cnt == LAST) &&
                     (bit_cnt == BW'(STOP_BITS - 1));
  assign hs        = rx_valid & rx_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (hs) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      // A frame completing against an unaccepted word is dropped; a same-cycle handshake makes room.
      if (last_stop) begin
        if (rx_valid && !rx_ready) overrun <= 1'b1;
        else begin
          rx_data    <= shreg;
          rx_valid   <= 1'b1;
          parity_err <= perr_new;
          frame_err  <= ferr_new;
        end
      end

      case (state)
        ST_IDLE: if (!rxd_s) begin
          state    <= ST_START;
          os_cnt   <= '0;
          bit_cnt  <= '0;
          ferr_acc <= 1'b0;
        end
        ST_WAIT_HIGH: if (rxd_s) state <= ST_IDLE;
        default: if (os_tick) begin
          os_cnt <= os_cnt + 1'b1;
          case (state)
            ST_START: if (os_cnt == MID) begin
              os_cnt <= '0;
              state  <= bit_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (os_cnt == LAST) begin
              os_cnt <= '0;
              shreg  <= {bit_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            ST_PARITY: if (os_cnt == LAST) begin
              os_cnt  <= '0;
              par_bit <= bit_s;
              state   <= ST_STOP;
            end
            ST_STOP: if (os_cnt == LAST) begin
              os_cnt   <= '0;
              ferr_acc <= ferr_new;
              if (bit_cnt == BW'(STOP_BITS - 1)) state <= ferr_new ? ST_WAIT_HIGH : ST_IDLE;
              else                               bit_cnt <= bit_cnt + 1'b1;
            end
            default: state <= ST_IDLE;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench: an 8N1 and an 8E1 receiver at CLK_DIV=4, OVS=16 (64 clk per bit).
module tb_uart_rx_os;

  logic clk = 1'b0, rst_n = 1'b0, line = 1'b1, sel = 1'b0, rdy = 1'b1;
  logic rxd_m, rxd_p;
  logic [7:0] data_m, data_p;
  logic vld_m, perr_m, ferr_m, ovr_m, busy_m;
  logic vld_p, perr_p, ferr_p, ovr_p, busy_p;

  assign rxd_m = sel ? 1'b1 : line;
  assign rxd_p = sel ? line : 1'b1;

  uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVS(16), .CLK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_m), .rx_data(data_m), .rx_valid(vld_m),
    .rx_ready(rdy), .parity_err(perr_m), .frame_err(ferr_m), .overrun(ovr_m), .busy(busy_m)
  );

  uart_rx_os #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVS(16), .CLK_DIV(4)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_p), .rx_data(data_p), .rx_valid(vld_p),
    .rx_ready(1'b1), .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_m[$], q_p[$];
  exp_t em, ep;
  int n_cmp = 0, n_bad = 0;
  int t0, got;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && vld_m && rdy) begin
      n_cmp++;
      if (q_m.size() == 0) begin
        n_bad++;
        $display("FAIL mon_8n1: unexpected word %02h pe=%b fe=%b", data_m, perr_m, ferr_m);
      end else begin
        em = q_m.pop_front();
        if ({data_m, perr_m, ferr_m} !== {em.d, em.pe, em.fe}) begin
          n_bad++;
          $display("FAIL mon_8n1: got %02h pe=%b fe=%b expected %02h pe=%b fe=%b",
                   data_m, perr_m, ferr_m, em.d, em.pe, em.fe);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld_p) begin
      n_cmp++;
      if (q_p.size() == 0) begin
        n_bad++;
        $display("FAIL mon_8e1: unexpected word %02h pe=%b fe=%b", data_p, perr_p, ferr_p);
      end else begin
        ep = q_p.pop_front();
        if ({data_p, perr_p, ferr_p} !== {ep.d, ep.pe, ep.fe}) begin
          n_bad++;
          $display("FAIL mon_8e1: got %02h pe=%b fe=%b expected %02h pe=%b fe=%b",
                   data_p, perr_p, ferr_p, ep.d, ep.pe, ep.fe);
        end
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input bit par_en, input logic pbit, input logic sbit);
    line = 1'b0;
    tick_n(64);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      tick_n(64);
    end
    if (par_en) begin
      line = pbit;
      tick_n(64);
    end
    line = sbit;
    tick_n(64);
    line = 1'b1;
  endtask

  initial begin
    tick_n(3);
    chk("rst_valid", vld_m, 0);
    chk("rst_data", data_m, 0);
    chk("rst_flags", {perr_m, ferr_m, ovr_m}, 0);
    chk("rst_busy", busy_m, 0);
    rst_n = 1'b1;
    tick_n(5);

    // 8N1 0xA5: latency from the falling edge and a one-clk valid pulse
    q_m.push_back('{8'hA5, 1'b0, 1'b0});
    fork
      send(8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        t0 = cyc;
        got = 0;
        for (int i = 0; i < 1000 && got == 0; i++) begin
          @(negedge clk);
          if (vld_m) begin
            got = 1;
            chk("latency_a5", cyc - t0, 611);
          end
        end
        if (got == 0) chk("latency_a5_timeout", 0, 1);
        @(negedge clk);
        chk("pulse_a5", vld_m, 0);
      end
    join
    tick_n(64);

    // 20-clk glitch: false start rejected at the mid-start sample
    line = 1'b0;
    tick_n(20);
    line = 1'b1;
    tick_n(14);
    chk("glitch_busy_34", busy_m, 1);
    tick_n(1);
    chk("glitch_busy_35", busy_m, 0);
    tick_n(64);

    // 8E1 receiver: wrong, correct, and odd-popcount parity
    sel = 1'b1;
    tick_n(8);
    q_p.push_back('{8'h3C, 1'b1, 1'b0});
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    tick_n(64);
    q_p.push_back('{8'h3C, 1'b0, 1'b0});
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    tick_n(64);
    q_p.push_back('{8'h07, 1'b0, 1'b0});
    send(8'h07, 1'b1, 1'b1, 1'b1);
    tick_n(64);
    sel = 1'b0;
    tick_n(8);

    // Break: one 0x00 frame-error word, then hold until the line returns high
    q_m.push_back('{8'h00, 1'b0, 1'b1});
    line = 1'b0;
    tick_n(700);
    chk("break_wait_busy", busy_m, 1);
    tick_n(68);
    line = 1'b1;
    tick_n(4);
    chk("break_idle", busy_m, 0);
    tick_n(64);
    q_m.push_back('{8'h81, 1'b0, 1'b0});
    send(8'h81, 1'b0, 1'b0, 1'b1);
    tick_n(64);

    // Overrun: second word dropped while the first is held
    rdy = 1'b0;
    q_m.push_back('{8'h11, 1'b0, 1'b0});
    send(8'h11, 1'b0, 1'b0, 1'b1);
    tick_n(16);
    chk("ovr_before", ovr_m, 0);
    send(8'h22, 1'b0, 1'b0, 1'b1);
    tick_n(16);
    chk("ovr_data_held", data_m, 8'h11);
    chk("ovr_valid_held", vld_m, 1);
    chk("ovr_set", ovr_m, 1);
    rdy = 1'b1;
    tick_n(1);
    rdy = 1'b0;
    chk("ovr_valid_clr", vld_m, 0);
    chk("ovr_clr", ovr_m, 0);
    tick_n(64);

    // Reset mid-frame with a word held
    send(8'h33, 1'b0, 1'b0, 1'b1);
    tick_n(16);
    chk("pre_rst_valid", vld_m, 1);
    chk("pre_rst_data", data_m, 8'h33);
    line = 1'b0;
    tick_n(64);
    line = 1'b1;
    tick_n(200);
    chk("pre_rst_busy", busy_m, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", vld_m, 0);
    chk("mid_rst_data", data_m, 0);
    chk("mid_rst_busy", busy_m, 0);
    chk("mid_rst_flags", {perr_m, ferr_m, ovr_m}, 0);
    tick_n(3);
    rst_n = 1'b1;
    rdy = 1'b1;
    tick_n(64);
    q_m.push_back('{8'h5A, 1'b0, 1'b0});
    send(8'h5A, 1'b0, 1'b0, 1'b1);
    tick_n(64);

    chk("queue_8n1_empty", q_m.size(), 0);
    chk("queue_8e1_empty", q_p.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
